// File: rtl/tnew_pipe_pkg.sv
// Purpose: constants and the shared tnew decrement helper for the E/M/W latency tracker and hazard controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package tnew_pipe_pkg;

    localparam int TNEW_W = 4;
    localparam int REG_W  = 5;

    // Sticky code for results produced by the mult/div unit: the real
    // latency is unknown, so the hazard controller keeps stalling on it.
    localparam logic [TNEW_W-1:0] TNEW_MD  = 4'd5;
    localparam logic [REG_W-1:0]  REG_ZERO = 5'd0;

    // One stage of progress: the sticky code stays put, zero saturates,
    // everything else counts down by one.
    function automatic logic [TNEW_W-1:0] tnew_dec(
        input logic [TNEW_W-1:0] x,
        input logic [TNEW_W-1:0] md
    );
        if (x == md) begin
            return md;
        end else if (x == '0) begin
            return '0;
        end else begin
            return x - 4'd1;
        end
    endfunction

endpackage

// File: rtl/tnew_stage.sv
// Purpose: one pipeline register pair (tnew, writereg) with hold and optional decrement on capture.
// Latency: 1 cycle from tnew_nxt/writereg_nxt to outputs.
// Backpressure: hold=1 freezes the stage (no decrement); upstream is not told.
// Ports: clk, reset (async high), hold, dec_en, tnew_nxt/writereg_nxt in; tnew/writereg out (registered).
module tnew_stage
    import tnew_pipe_pkg::*;
#(
    parameter logic [TNEW_W-1:0] MD = TNEW_MD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              dec_en,
    input  logic [TNEW_W-1:0] tnew_nxt,
    input  logic [REG_W-1:0]  writereg_nxt,
    output logic [TNEW_W-1:0] tnew,
    output logic [REG_W-1:0]  writereg
);

    logic [TNEW_W-1:0] tnew_d, tnew_q;
    logic [REG_W-1:0]  writereg_d, writereg_q;

    always_comb begin
        tnew_d     = tnew_q;
        writereg_d = writereg_q;
        if (!hold) begin
            tnew_d     = dec_en ? tnew_dec(tnew_nxt, MD) : tnew_nxt;
            writereg_d = writereg_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tnew_q     <= '0;
            writereg_q <= REG_ZERO;
        end else begin
            tnew_q     <= tnew_d;
            writereg_q <= writereg_d;
        end
    end

    assign tnew     = tnew_q;
    assign writereg = writereg_q;

endmodule

// File: rtl/tnew_pipe.sv
// Purpose: tracks remaining result latency (tnew) and destination register through E, M, W for hazard detection.
// Latency: decode value on E after 1 cycle, M after 2, W after 3; outputs come straight from flops.
// Backpressure: stalle/stallm/stallw hold their stage; stalld injects a bubble into E and is counted.
// Ports: clk, reset (async high), tnew_D/writereg_D, stalld, stalle/stallm/stallw in;
//        tnew_E/M/W, writereg_E/M/W, bubble_cnt out.
module tnew_pipe
    import tnew_pipe_pkg::*;
#(
    parameter logic [TNEW_W-1:0] TNEW_MD = tnew_pipe_pkg::TNEW_MD,
    parameter int                CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TNEW_W-1:0] tnew_D,
    input  logic [REG_W-1:0]  writereg_D,
    input  logic              stalld,
    input  logic              stalle,
    input  logic              stallm,
    input  logic              stallw,
    output logic [TNEW_W-1:0] tnew_E,
    output logic [TNEW_W-1:0] tnew_M,
    output logic [TNEW_W-1:0] tnew_W,
    output logic [REG_W-1:0]  writereg_E,
    output logic [REG_W-1:0]  writereg_M,
    output logic [REG_W-1:0]  writereg_W,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [TNEW_W-1:0] tnew_e_d, tnew_e_q;
    logic [REG_W-1:0]  writereg_e_d, writereg_e_q;
    logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
    logic              bubble;

    // A bubble only enters E when E itself is free to load; a stalled E
    // (including the all-stall error freeze) swallows the decode stall.
    assign bubble = stalld && !stalle;

    always_comb begin
        tnew_e_d     = tnew_e_q;
        writereg_e_d = writereg_e_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!stalle) begin
            if (stalld) begin
                tnew_e_d     = '0;
                writereg_e_d = REG_ZERO;
            end else begin
                tnew_e_d     = tnew_D;
                writereg_e_d = writereg_D;
            end
        end
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tnew_e_q     <= '0;
            writereg_e_q <= REG_ZERO;
            bubble_cnt_q <= '0;
        end else begin
            tnew_e_q     <= tnew_e_d;
            writereg_e_q <= writereg_e_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // M and W copy upstream even when upstream is held; the hazard
    // controller tolerates the resulting duplicate entries.
    tnew_stage #(.MD(TNEW_MD)) u_stage_m (
        .clk          (clk),
        .reset        (reset),
        .hold         (stallm),
        .dec_en       (1'b1),
        .tnew_nxt     (tnew_e_q),
        .writereg_nxt (writereg_e_q),
        .tnew         (tnew_M),
        .writereg     (writereg_M)
    );

    tnew_stage #(.MD(TNEW_MD)) u_stage_w (
        .clk          (clk),
        .reset        (reset),
        .hold         (stallw),
        .dec_en       (1'b1),
        .tnew_nxt     (tnew_M),
        .writereg_nxt (writereg_M),
        .tnew         (tnew_W),
        .writereg     (writereg_W)
    );

    assign tnew_E     = tnew_e_q;
    assign writereg_E = writereg_e_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_tnew_pipe.sv
// Purpose: directed self-checking bench for tnew_pipe with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall inputs driven directly from the stimulus sequence.
module tb_tnew_pipe;

    logic        clk;
    logic        reset;
    logic [3:0]  tnew_D;
    logic [4:0]  writereg_D;
    logic        stalld, stalle, stallm, stallw;
    logic [3:0]  tnew_E, tnew_M, tnew_W;
    logic [4:0]  writereg_E, writereg_M, writereg_W;
    logic [31:0] bubble_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    tnew_pipe #(.TNEW_MD(4'd5), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .tnew_D     (tnew_D),
        .writereg_D (writereg_D),
        .stalld     (stalld),
        .stalle     (stalle),
        .stallm     (stallm),
        .stallw     (stallw),
        .tnew_E     (tnew_E),
        .tnew_M     (tnew_M),
        .tnew_W     (tnew_W),
        .writereg_E (writereg_E),
        .writereg_M (writereg_M),
        .writereg_W (writereg_W),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_e(input string tag, input logic [3:0] et, input logic [4:0] ew);
        chk({tag, ".tnew_E"}, 32'(tnew_E), 32'(et));
        chk({tag, ".writereg_E"}, 32'(writereg_E), 32'(ew));
    endtask

    task automatic chk_m(input string tag, input logic [3:0] et, input logic [4:0] ew);
        chk({tag, ".tnew_M"}, 32'(tnew_M), 32'(et));
        chk({tag, ".writereg_M"}, 32'(writereg_M), 32'(ew));
    endtask

    task automatic chk_w(input string tag, input logic [3:0] et, input logic [4:0] ew);
        chk({tag, ".tnew_W"}, 32'(tnew_W), 32'(et));
        chk({tag, ".writereg_W"}, 32'(writereg_W), 32'(ew));
    endtask

    task automatic chk_b(input string tag, input logic [31:0] eb);
        chk({tag, ".bubble_cnt"}, bubble_cnt, eb);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] t, input logic [4:0] w);
        tnew_D     = t;
        writereg_D = w;
    endtask

    initial begin
        reset  = 1'b1;
        stalld = 1'b0; stalle = 1'b0; stallm = 1'b0; stallw = 1'b0;
        drv(4'd0, 5'd0);
        #2;
        chk_e("rst", 4'd0, 5'd0);
        chk_m("rst", 4'd0, 5'd0);
        chk_w("rst", 4'd0, 5'd0);
        chk_b("rst", 32'd0);
        #10;
        reset = 1'b0;

        // Single instruction walking down the pipe, counting 2 -> 1 -> 0.
        drv(4'd2, 5'd8);
        cyc(); chk_e("walk1", 4'd2, 5'd8);
        drv(4'd0, 5'd0);
        cyc(); chk_m("walk2", 4'd1, 5'd8); chk_e("walk2", 4'd0, 5'd0);
        cyc(); chk_w("walk3", 4'd0, 5'd8);

        // Sticky mult/div code never decrements.
        drv(4'd5, 5'd0);
        cyc(); chk_e("md1", 4'd5, 5'd0);
        drv(4'd0, 5'd0);
        cyc(); chk("md2.tnew_M", 32'(tnew_M), 32'd5);
        cyc(); chk("md3.tnew_W", 32'(tnew_W), 32'd5);

        // Decode stall: three bubbles, then the held instruction enters E.
        stalld = 1'b1;
        drv(4'd3, 5'd4);
        for (int i = 1; i <= 3; i++) begin
            cyc(); chk_e("bub", 4'd0, 5'd0); chk_b("bub", 32'(i));
        end
        stalld = 1'b0;
        cyc(); chk_e("bub_rel", 4'd3, 5'd4); chk_b("bub_rel", 32'd3);

        // Fill stages with E=(2,5), M=(1,6), W=(0,7).
        drv(4'd2, 5'd7); cyc();
        chk_m("fill", 4'd2, 5'd4);
        drv(4'd2, 5'd6); cyc();
        drv(4'd2, 5'd5); cyc();
        chk_e("fill", 4'd2, 5'd5); chk_m("fill", 4'd1, 5'd6); chk_w("fill", 4'd0, 5'd7);

        // Error freeze: everything held, stalld ignored, no bubble counted.
        stalld = 1'b1; stalle = 1'b1; stallm = 1'b1; stallw = 1'b1;
        drv(4'd9, 5'd31);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_e("frz", 4'd2, 5'd5); chk_m("frz", 4'd1, 5'd6); chk_w("frz", 4'd0, 5'd7);
            chk_b("frz", 32'd3);
        end
        stalld = 1'b0; stalle = 1'b0; stallm = 1'b0; stallw = 1'b0;

        // Build M=(2,9).
        drv(4'd3, 5'd9); cyc();
        chk_m("pre_m", 4'd1, 5'd5); chk_w("pre_m", 4'd0, 5'd6);
        drv(4'd0, 5'd0); cyc();
        chk_m("pre_m2", 4'd2, 5'd9);

        // M held: no decrement in M, W keeps copying (1,9), E keeps loading.
        stallm = 1'b1;
        drv(4'd4, 5'd3);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_m("mhold", 4'd2, 5'd9); chk_w("mhold", 4'd1, 5'd9); chk_e("mhold", 4'd4, 5'd3);
        end
        stallm = 1'b0;
        drv(4'd0, 5'd0);
        cyc(); chk_m("mrel", 4'd3, 5'd3); chk_w("mrel", 4'd1, 5'd9);
        // E now holds 0: decrement must saturate rather than wrap to 15.
        cyc(); chk_m("sat0", 4'd0, 5'd0); chk_w("sat0", 4'd2, 5'd3);

        // Asynchronous reset in the middle of a full stall.
        drv(4'd7, 5'd12); cyc();
        stalld = 1'b1; stalle = 1'b1; stallm = 1'b1; stallw = 1'b1;
        cyc(); chk_e("pre_ar", 4'd7, 5'd12); chk_b("pre_ar", 32'd3);
        #2 reset = 1'b1;
        #1;
        chk_e("arst", 4'd0, 5'd0); chk_m("arst", 4'd0, 5'd0); chk_w("arst", 4'd0, 5'd0);
        chk_b("arst", 32'd0);
        #2;
        reset  = 1'b0;
        stalld = 1'b0; stalle = 1'b0; stallm = 1'b0; stallw = 1'b0;
        drv(4'd2, 5'd8);
        cyc(); chk_e("post_ar", 4'd2, 5'd8); chk_m("post_ar", 4'd0, 5'd0); chk_b("post_ar", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time bound so a broken run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tnew_pipe.md
TNEW_PIPE -- requirements
Module: tnew_pipe

Interface
REQ-001 SHALL have parameter TNEW_MD, default 5: sticky tnew code for mult/div-busy producers, never decremented.
REQ-002 SHALL have parameter CNT_W, default 32: width of the bubble performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 tnew_D  input  4  cycles-until-result of the instruction leaving decode.
REQ-006 writereg_D  input  5  destination register of the decode instruction; 0 means no write.
REQ-007 stalld  input  1  decode stall from hazard controller; causes a bubble into E.
REQ-008 stalle, stallm, stallw  input  1 each  hold E, M and W stage registers respectively.
REQ-009 tnew_E, tnew_M, tnew_W  output  4 each  registered remaining-latency per stage, fed to hazard controller.
REQ-010 writereg_E, writereg_M, writereg_W  output  5 each  registered destination per stage.
REQ-011 bubble_cnt  output  CNT_W  number of bubbles inserted into E since reset.

Function
REQ-012 E update priority: stalle -> hold; else stalld -> bubble (tnew_E=0, writereg_E=0); else tnew_E=tnew_D, writereg_E=writereg_D.
REQ-013 M update: stallm -> hold; else writereg_M=writereg_E, tnew_M=dec(tnew_E).
REQ-014 W update: stallw -> hold; else writereg_W=writereg_M, tnew_W=dec(tnew_M).
REQ-015 dec(x): x==TNEW_MD -> TNEW_MD; x==0 -> 0 (saturate, no wrap); otherwise x-1.
REQ-016 A held stage SHALL NOT decrement its tnew.
REQ-017 Downstream stage advancing while upstream holds SHALL still copy the upstream contents (duplication is legal; controller handles it).
REQ-018 stalle=stallm=stallw=1 (error freeze) SHALL hold all three stages regardless of stalld; bubble_cnt unchanged.
REQ-019 bubble_cnt SHALL increment by 1 exactly on each cycle where stalld=1 and stalle=0; saturates at all-ones.
REQ-020 writereg_D=0 SHALL be forwarded as-is with its tnew; no special casing besides bubble.
REQ-021 Latency: decode value visible on tnew_E/writereg_E one cycle after unstalled capture; on M after 2, W after 3.
REQ-022 Outputs SHALL be driven directly from registers, no combinational path from inputs.

Reset
REQ-023 reset=1 SHALL asynchronously set all tnew_* to 0, all writereg_* to 0, bubble_cnt to 0.
REQ-024 Reset asserted mid-stall SHALL override stall holds; first post-reset edge follows REQ-012..014 normally.
REQ-025 No initial blocks for functional reset; reset is the only initialisation path.

Structure
REQ-026 Shared package SHALL hold TNEW_MD, REG_ZERO (5'd0), TNEW_W (4) constants used also by the hazard controller.
REQ-027 One sub-module tnew_stage (hold input, next tnew/writereg inputs, decrement enable) SHALL be instantiated for M and W; E is coded inline due to bubble mux.
REQ-028 Decrement function SHALL be a single shared function in the package.

Verification
REQ-029 Reset, then tnew_D=2, writereg_D=8 for one cycle, no stalls -> E=(2,8), M=(1,8), W=(0,8) on successive cycles.
REQ-030 tnew_D=5, writereg_D=0 through pipe -> tnew_E=5, tnew_M=5, tnew_W=5 (sticky).
REQ-031 stalld=1 for 3 cycles with tnew_D=3, writereg_D=4 -> E=(0,0) each cycle, bubble_cnt=3; on release E=(3,4).
REQ-032 All stall inputs=1 for 4 cycles with stages (2,5)/(1,6)/(0,7) -> stages unchanged, bubble_cnt unchanged.
REQ-033 stallm=1 only, M=(2,9) -> tnew_M stays 2; W receives (1,9) each cycle.
REQ-034 Assert reset asynchronously mid-cycle during stalls -> all outputs 0 before next clock edge.
